// File: rtl/osc_clk_divider_pkg.sv
// Shared definitions for the oscillator clock divider.
// Holds the parameter defaults and the channel-index width helper.
// Imported by the interface, the per-channel divider and the top level.
package osc_div_pkg;

  // Default divisor width; the largest divisor is 2^DIV_WIDTH-1.
  localparam int unsigned DIV_WIDTH_DEF   = 8;

  // Divisor loaded into every channel at reset.
  localparam int unsigned DEFAULT_DIV_DEF = 2;

  // Width of the channel-select field. A single-channel build still gets
  // one select bit, so div_ch never collapses to a zero-width vector.
  function automatic int unsigned ch_idx_w(input int unsigned channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/osc_clk_divider_if.sv
// Control/status bundle of the oscillator clock divider.
// master: en, sync, div_wr, div_ch, div_val out; tick, clk_out, pending in.
// slave : the divider side, directions mirrored.
interface osc_clk_divider_if
  import osc_div_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
);

  localparam int unsigned CH_W = ch_idx_w(CHANNELS);

  logic [CHANNELS-1:0]  en;       // per-channel run enable
  logic                 sync;     // one-cycle pulse, phase-aligns all channels
  logic                 div_wr;   // divisor write strobe
  logic [CH_W-1:0]      div_ch;   // target channel of div_wr
  logic [DIV_WIDTH-1:0] div_val;  // divisor written by div_wr
  logic [CHANNELS-1:0]  tick;     // one-cycle strobe per channel period
  logic [CHANNELS-1:0]  clk_out;  // registered divided square wave
  logic [CHANNELS-1:0]  pending;  // written divisor awaiting application

  modport master (
    output en, sync, div_wr, div_ch, div_val,
    input  tick, clk_out, pending
  );

  modport slave (
    input  en, sync, div_wr, div_ch, div_val,
    output tick, clk_out, pending
  );

endinterface

// File: rtl/osc_clk_divider_channel.sv
// One divider channel: counts clkin edges modulo N and emits tick/clk_out.
// Ports: clkin/reset; en, sync, wr, wr_val in; tick, clk_out, pending out.
// Latency: outputs are registered straight from the counter; no handshake,
// a write is always accepted (held pending until the next period boundary).
module osc_div_channel
  import osc_div_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 wr,       // write already decoded for this channel
  input  logic [DIV_WIDTH-1:0] wr_val,
  output logic                 tick,
  output logic                 clk_out,
  output logic                 pending
);

  logic [DIV_WIDTH-1:0] act_div;   // divisor governing the current period
  logic [DIV_WIDTH-1:0] pend_div;  // divisor waiting for the next boundary
  logic [DIV_WIDTH-1:0] cnt;       // position inside the current period
  logic [DIV_WIDTH-1:0] eff_n;     // active divisor with 0 treated as 1
  logic                 at_wrap;   // this edge ends the current period
  logic                 restart;   // this edge starts a new period
  logic                 in_high;   // counter sits in the high half of the wave

  always_comb begin
    eff_n   = (act_div == '0) ? DIV_WIDTH'(1) : act_div;
    at_wrap = (cnt == eff_n - DIV_WIDTH'(1));
    restart = sync | at_wrap;
    // floor(N/2): odd N gets the shorter high phase, N=1 never goes high.
    in_high = (cnt < (eff_n >> 1));
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      act_div  <= DIV_WIDTH'(DEFAULT_DIV);
      pend_div <= '0;
      pending  <= 1'b0;
      cnt      <= '0;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
    end else if (!en) begin
      // Idle channel: park the counter and hand over any queued divisor now.
      // A write arriving this same edge is newer, so it wins.
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      pending <= 1'b0;
      if (wr) begin
        act_div <= wr_val;
      end else if (pending) begin
        act_div <= pend_div;
      end
    end else begin
      // sync restarts the period without emitting the end-of-period strobe.
      tick    <= at_wrap & ~sync;
      clk_out <= in_high;
      cnt     <= restart ? '0 : cnt + DIV_WIDTH'(1);
      if (restart && pending) begin
        act_div <= pend_div;
        pending <= 1'b0;
      end
      // Placed after the load so a write on a boundary edge stays queued
      // for the following boundary instead of taking effect immediately.
      if (wr) begin
        pend_div <= wr_val;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/osc_clk_divider.sv
// Multi-channel divider of the on-chip oscillator clock.
// Ports: clkin, reset (sync, active high); bus (slave) carries enables,
// sync, divisor writes and the per-channel tick/clk_out/pending outputs.
// Latency: outputs registered, no input-to-output combinational path;
// divisor writes are never refused.
module osc_clk_divider
  import osc_div_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic               clkin,
  input  logic               reset,
  osc_clk_divider_if.slave   bus
);

  localparam int unsigned CH_W = ch_idx_w(CHANNELS);

  // Write decode: a channel index beyond CHANNELS-1 matches no channel,
  // so such writes fall away without extra range logic.
  logic [CHANNELS-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_hit[c] = bus.div_wr && (bus.div_ch == CH_W'(c));
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    osc_div_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clkin   (clkin),
      .reset   (reset),
      .en      (bus.en[c]),
      .sync    (bus.sync),          // shared fan-out to every channel
      .wr      (wr_hit[c]),
      .wr_val  (bus.div_val),
      .tick    (bus.tick[c]),
      .clk_out (bus.clk_out[c]),
      .pending (bus.pending[c])
    );
  end

endmodule
